// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains 32-bit words from the output FIFO and sends each one as
// four UART 8N1 frames (least-significant byte first, LSB-first bits) on tx.
// The read port is standard (non-FWFT): data is valid the cycle after the pop.

module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 868,  // clk cycles per UART bit, 2..65535
  parameter int CNT_W        = 16    // width of the words_sent counter
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [31:0]      fifo_rd_data,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy,
  output logic [1:0]       byte_idx,
  output logic [CNT_W-1:0] words_sent
);

  typedef enum logic [2:0] {
    IDLE,   // line high, waiting for a word
    POP,    // one-cycle read strobe to the FIFO
    LOAD,   // FIFO data is valid now; capture it
    START,  // start bit (low)
    DATA,   // eight data bits, LSB first
    STOP    // stop bit (high), then next byte or next word
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [31:0] shift_word;

  logic        baud_done;
  logic [2:0]  bit_next;
  logic [7:0]  cur_byte;

  // Bit-timing and byte-select helpers for the sequencer.
  assign baud_done = (baud_cnt == BAUD_LAST);
  assign bit_next  = bit_idx + 3'd1;
  assign cur_byte  = shift_word[{byte_idx, 3'b000} +: 8];

  // Transmit sequencer: state, baud/bit counters and all registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order in this block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      byte_idx   <= 2'd0;
      bit_idx    <= 3'd0;
      baud_cnt   <= 16'd0;
      words_sent <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!fifo_empty) begin
            state      <= POP;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end

        POP: begin
          fifo_rd_en <= 1'b0;
          state      <= LOAD;
        end

        LOAD: begin
          // NOTE: shift_word is pure datapath and is always written here before
          // it is read, so it needs no reset term.
          shift_word <= fifo_rd_data;
          byte_idx   <= 2'd0;
          bit_idx    <= 3'd0;
          baud_cnt   <= 16'd0;
          tx         <= 1'b0;
          state      <= START;
        end

        START: begin
          if (baud_done) begin
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            tx       <= cur_byte[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        DATA: begin
          if (baud_done) begin
            baud_cnt <= 16'd0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_next;
              tx      <= cur_byte[bit_next];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        STOP: begin
          if (baud_done) begin
            baud_cnt <= 16'd0;
            if (byte_idx != 2'd3) begin
              // Next byte of the same word follows with no gap.
              byte_idx <= byte_idx + 2'd1;
              bit_idx  <= 3'd0;
              tx       <= 1'b0;
              state    <= START;
            end else begin
              words_sent <= words_sent + 1'b1;
              byte_idx   <= 2'd0;
              if (!fifo_empty) begin
                // Back-to-back word: POP and LOAD give a two-cycle high gap.
                state      <= POP;
                fifo_rd_en <= 1'b1;
                busy       <= 1'b1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        default: begin
          state      <= IDLE;
          tx         <= 1'b1;
          fifo_rd_en <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
